// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Two-host arbiter for the shared single-port SoC SRAM. Muxes the core's
//   instruction-fetch and load/store ports onto one memory port. Data wins
//   by default; a fetch that has lost MaxWait consecutive cycles takes
//   priority. Responses return in order and are routed back to their host
//   through a 2-entry owner FIFO.
//
//   Optional feature (macro SRAM_ARB_RANGE_CHECK_EN): requests outside
//   [MemBase, MemBase+MemSize) are not forwarded to the SRAM; they are
//   granted locally and answered in order with err_o = 1, rdata_o = 0.
//
// Ports
//   clk_sys_i, rst_sys_i         clock, synchronous active-high reset
//   instr_req_i/addr_i           fetch request (read only)
//   instr_gnt_o/rvalid_o         fetch grant (combinational) / response
//   data_req_i/we_i/be_i/
//   data_addr_i/wdata_i          load/store request
//   data_gnt_o/rvalid_o          load/store grant (combinational) / response
//   rdata_o, err_o               shared response data/error, qualified by
//                                the per-host rvalid
//   mem_req_o/we_o/be_o/
//   mem_addr_o/wdata_o           SRAM request; data fields are 0 when idle
//   mem_gnt_i, mem_rvalid_i,
//   mem_rdata_i                  SRAM handshake and in-order read response
module sram_port_arbiter #(
   parameter logic [31:0] MemBase = 32'h0000_0000,
   parameter logic [31:0] MemSize = 32'h0001_0000,
   parameter int unsigned MaxWait = 4
) (
   input  logic        clk_sys_i,
   input  logic        rst_sys_i,
   input  logic        instr_req_i,
   input  logic [31:0] instr_addr_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   input  logic        data_req_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [31:0] rdata_o,
   output logic        err_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i
);

   localparam int unsigned StarveW = $clog2(MaxWait + 1);

   typedef enum logic {
      OwnInstr = 1'b0,
      OwnData  = 1'b1
   } owner_e;

   // Elaboration-time sanity checks on the configuration.
   if (MaxWait < 1 || MaxWait > 15) begin : g_bad_maxwait
      $error("MaxWait must be in 1..15");
   end
   if (MemSize == 32'd0 || (MemSize & (MemSize - 32'd1)) != 32'd0) begin : g_bad_size
      $error("MemSize must be a non-zero power of two");
   end
   if (({1'b0, MemBase} + {1'b0, MemSize}) > 33'h1_0000_0000) begin : g_bad_window
      $error("SRAM window wraps past the top of the address space");
   end

   logic [1:0]         count_q, count_d;
   owner_e             fifo_own_q [2];
   owner_e             fifo_own_d [2];
   logic [1:0]         fifo_err_q, fifo_err_d;
   logic [StarveW-1:0] starve_q, starve_d;

   logic        starve_hit;
   logic        sel_data, sel_instr, sel_any, sel_err;
   logic [31:0] sel_addr;
   logic        fifo_full, accept, head_valid, rsp_fire;

   // Host selection and range classification
   always_comb begin
      starve_hit = (starve_q == StarveW'(MaxWait));
      sel_data   = data_req_i && !(instr_req_i && starve_hit);
      sel_instr  = instr_req_i && !sel_data;
      sel_any    = sel_data || sel_instr;
      sel_addr   = sel_data ? data_addr_i : instr_addr_i;
   end

`ifdef SRAM_ARB_RANGE_CHECK_EN
   logic [31:0] addr_off;
   // Offset compare avoids overflow of MemBase + MemSize at the top of memory.
   always_comb begin
      addr_off = sel_addr - MemBase;
      sel_err  = sel_any && (addr_off >= MemSize);
   end
`else
   always_comb sel_err = 1'b0;
`endif

   // Request path
   always_comb begin
      fifo_full   = count_q[1];
      // Out-of-range requests are accepted locally and never reach the SRAM.
      accept      = sel_any && !fifo_full && !rst_sys_i && (sel_err || mem_gnt_i);
      mem_req_o   = sel_any && !fifo_full && !rst_sys_i && !sel_err;
      instr_gnt_o = accept && sel_instr;
      data_gnt_o  = accept && sel_data;

      mem_we_o    = 1'b0;
      mem_be_o    = '0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (mem_req_o) begin
         mem_addr_o = sel_addr;
         if (sel_data) begin
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_wdata_o = data_wdata_i;
         end else begin
            mem_be_o = '1;
         end
      end
   end

   // Response path: an err entry completes on its own, otherwise the head
   // waits for the SRAM's in-order rvalid.
   always_comb begin
      head_valid     = (count_q != 2'd0) && !rst_sys_i;
      rsp_fire       = head_valid && (fifo_err_q[0] || mem_rvalid_i);
      instr_rvalid_o = rsp_fire && (fifo_own_q[0] == OwnInstr);
      data_rvalid_o  = rsp_fire && (fifo_own_q[0] == OwnData);
      err_o          = rsp_fire && fifo_err_q[0];
      rdata_o        = (rsp_fire && !fifo_err_q[0]) ? mem_rdata_i : '0;
   end

   // Owner FIFO (head at index 0) and starvation counter next state.
   // Pop shifts first so a same-cycle push lands at the post-pop tail.
   always_comb begin
      count_d    = count_q;
      fifo_own_d = fifo_own_q;
      fifo_err_d = fifo_err_q;
      if (rsp_fire) begin
         fifo_own_d[0] = fifo_own_q[1];
         fifo_err_d[0] = fifo_err_q[1];
         count_d       = count_q - 2'd1;
      end
      if (accept) begin
         fifo_own_d[count_d[0]] = sel_data ? OwnData : OwnInstr;
         fifo_err_d[count_d[0]] = sel_err;
         count_d                = count_d + 2'd1;
      end

      starve_d = '0;
      if (instr_req_i && !instr_gnt_o) begin
         starve_d = starve_hit ? starve_q : starve_q + 1'b1;
      end
   end

   always_ff @(posedge clk_sys_i) begin
      if (rst_sys_i) begin
         count_q       <= '0;
         starve_q      <= '0;
         fifo_own_q[0] <= OwnInstr;
         fifo_own_q[1] <= OwnInstr;
         fifo_err_q    <= '0;
      end else begin
         count_q    <= count_d;
         starve_q   <= starve_d;
         fifo_own_q <= fifo_own_d;
         fifo_err_q <= fifo_err_d;
      end
   end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: a directed vector table, hand
// sequences for starvation and range errors, then randomized traffic, all
// compared every cycle against a queue-based reference model and a
// behavioural 1-cycle SRAM.
module tb_sram_port_arbiter;

   localparam logic [31:0] MemBaseTb = 32'h0000_0000;
   localparam logic [31:0] MemSizeTb = 32'h0001_0000;
   localparam int unsigned MaxWaitTb = 4;
`ifdef SRAM_ARB_RANGE_CHECK_EN
   localparam bit RangeEn = 1'b1;
`else
   localparam bit RangeEn = 1'b0;
`endif

   logic        clk_sys_i = 1'b0;
   logic        rst_sys_i;
   logic        instr_req_i;
   logic [31:0] instr_addr_i;
   logic        instr_gnt_o, instr_rvalid_o;
   logic        data_req_i, data_we_i;
   logic [3:0]  data_be_i;
   logic [31:0] data_addr_i, data_wdata_i;
   logic        data_gnt_o, data_rvalid_o;
   logic [31:0] rdata_o;
   logic        err_o;
   logic        mem_req_o, mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic        mem_gnt_i, mem_rvalid_i;
   logic [31:0] mem_rdata_i;

   sram_port_arbiter #(
      .MemBase(MemBaseTb),
      .MemSize(MemSizeTb),
      .MaxWait(MaxWaitTb)
   ) dut (
      .clk_sys_i(clk_sys_i), .rst_sys_i(rst_sys_i),
      .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
      .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
      .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
      .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
      .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
      .rdata_o(rdata_o), .err_o(err_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk_sys_i = ~clk_sys_i;

   typedef struct packed {
      logic        gi, gd, rvi, rvd, err, mr, mwe;
      logic [3:0]  mbe;
      logic [31:0] maddr, mwdata, rdata;
   } obs_t;

   typedef struct packed {
      bit own_data;
      bit err;
   } ent_t;

   typedef struct {
      bit          rst, ir;
      logic [31:0] iaddr;
      bit          dr, we;
      logic [3:0]  be;
      logic [31:0] daddr, wdata;
      bit          mg, hold;
      bit          gi, gd, mr, rvi, rvd;
      logic [31:0] rdata;
   } vec_t;

   int unsigned passed = 0;
   int unsigned total  = 0;

   // Reference model state
   ent_t        mq[$];
   int unsigned starve = 0;
   // Behavioural SRAM
   logic [31:0] sram [4096];
   logic [31:0] rsp_q[$];
   bit          hold = 1'b0;

   obs_t cur_exp, cur_act;
   vec_t vec [21];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
   endtask

   function automatic bit in_window(input logic [31:0] a);
      longint unsigned av = a;
      longint unsigned lo = MemBaseTb;
      longint unsigned sz = MemSizeTb;
      return (av >= lo) && (av < lo + sz);
   endfunction

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 9))
         0:       return 32'h2000_0000 | ($urandom & 32'hFC);
         1:       return MemBaseTb + MemSizeTb - 32'd4;
         2:       return MemBaseTb + MemSizeTb;
         default: return MemBaseTb + ($urandom_range(0, 4095) << 2);
      endcase
   endfunction

   // One clock cycle: present SRAM response, compare at the falling edge,
   // then advance model and SRAM to the next cycle.
   task automatic tick();
      obs_t        e;
      bit          pick_d, pick_i, oor, ok, pop;
      logic [31:0] sa;
      logic [11:0] idx;
      ent_t        ent;
      mem_rvalid_i = !hold && (rsp_q.size() != 0);
      mem_rdata_i  = mem_rvalid_i ? rsp_q[0] : $urandom;
      @(negedge clk_sys_i);

      pick_d = data_req_i && !(instr_req_i && starve == MaxWaitTb);
      pick_i = instr_req_i && !pick_d;
      sa     = pick_d ? data_addr_i : instr_addr_i;
      oor    = RangeEn && (pick_d || pick_i) && !in_window(sa);
      e      = '0;
      ok     = 1'b0;
      pop    = 1'b0;
      if (!rst_sys_i) begin
         ok   = (pick_d || pick_i) && (mq.size() < 2) && (oor || mem_gnt_i);
         e.mr = (pick_d || pick_i) && (mq.size() < 2) && !oor;
         if (e.mr) begin
            e.maddr  = sa;
            e.mwe    = pick_d ? data_we_i : 1'b0;
            e.mbe    = pick_d ? data_be_i : 4'hF;
            e.mwdata = pick_d ? data_wdata_i : 32'h0;
         end
         e.gi = ok && pick_i;
         e.gd = ok && pick_d;
         if (mq.size() > 0 && (mq[0].err || mem_rvalid_i)) begin
            pop     = 1'b1;
            e.rvd   = mq[0].own_data;
            e.rvi   = !mq[0].own_data;
            e.err   = mq[0].err;
            e.rdata = mq[0].err ? 32'h0 : mem_rdata_i;
         end
      end

      cur_exp = e;
      cur_act = '{instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, err_o,
                  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, rdata_o};
      chk("instr_gnt_o",    instr_gnt_o,    e.gi);
      chk("data_gnt_o",     data_gnt_o,     e.gd);
      chk("instr_rvalid_o", instr_rvalid_o, e.rvi);
      chk("data_rvalid_o",  data_rvalid_o,  e.rvd);
      chk("err_o",          err_o,          e.err);
      chk("rdata_o",        rdata_o,        e.rdata);
      chk("mem_req_o",      mem_req_o,      e.mr);
      chk("mem_we_o",       mem_we_o,       e.mwe);
      chk("mem_be_o",       mem_be_o,       e.mbe);
      chk("mem_addr_o",     mem_addr_o,     e.maddr);
      chk("mem_wdata_o",    mem_wdata_o,    e.mwdata);

      if (mem_rvalid_i) void'(rsp_q.pop_front());
      if (mem_req_o && mem_gnt_i) begin
         idx = mem_addr_o[13:2];
         if (mem_we_o) begin
            for (int b = 0; b < 4; b++)
               if (mem_be_o[b]) sram[idx][8*b +: 8] = mem_wdata_o[8*b +: 8];
            rsp_q.push_back(32'h0);
         end else begin
            rsp_q.push_back(sram[idx]);
         end
      end

      if (rst_sys_i) begin
         mq.delete();
         starve = 0;
      end else begin
         if (pop) void'(mq.pop_front());
         if (ok) begin
            ent.own_data = pick_d;
            ent.err      = oor;
            mq.push_back(ent);
         end
         if (instr_req_i && !e.gi) starve = (starve < MaxWaitTb) ? starve + 1 : starve;
         else starve = 0;
      end
      @(posedge clk_sys_i);
      #1;
   endtask

   initial begin
      bit instr_turn;
      for (int i = 0; i < 4096; i++) sram[i] = 32'hA500_0000 | i;
      sram[32'h80 >> 2] = 32'h0000_0013;

      //          rst ir iaddr     dr we be     daddr     wdata          mg hold gi gd mr rvi rvd rdata
      vec[0]  = '{1, 0, 32'h00, 0, 0, 4'hF, 32'h0,    32'h0,        1, 0,  0, 0, 0, 0, 0, 32'h0};
      vec[1]  = '{1, 1, 32'h80, 1, 1, 4'hF, 32'h1000, 32'hDEAD,     1, 0,  0, 0, 0, 0, 0, 32'h0};
      vec[2]  = '{1, 1, 32'h80, 1, 1, 4'hF, 32'h1000, 32'hDEAD,     1, 0,  0, 0, 0, 0, 0, 32'h0};
      vec[3]  = '{0, 0, 32'h00, 0, 0, 4'hF, 32'h0,    32'h0,        1, 0,  0, 0, 0, 0, 0, 32'h0};
      vec[4]  = '{0, 1, 32'h80, 0, 0, 4'hF, 32'h0,    32'h0,        1, 0,  1, 0, 1, 0, 0, 32'h0};
      vec[5]  = '{0, 0, 32'h00, 0, 0, 4'hF, 32'h0,    32'h0,        1, 0,  0, 0, 0, 1, 0, 32'h13};
      vec[6]  = '{0, 1, 32'h84, 1, 1, 4'hF, 32'h1000, 32'h12345678, 1, 0,  0, 1, 1, 0, 0, 32'h0};
      vec[7]  = '{0, 1, 32'h84, 1, 0, 4'hF, 32'h1000, 32'h0,        1, 0,  0, 1, 1, 0, 1, 32'h0};
      vec[8]  = '{0, 1, 32'h84, 0, 0, 4'hF, 32'h0,    32'h0,        1, 0,  1, 0, 1, 0, 1, 32'h12345678};
      vec[9]  = '{0, 0, 32'h00, 0, 0, 4'hF, 32'h0,    32'h0,        1, 0,  0, 0, 0, 1, 0, 32'hA500_0021};
      vec[10] = '{0, 0, 32'h00, 1, 0, 4'hF, 32'h10,   32'h0,        1, 1,  0, 1, 1, 0, 0, 32'h0};
      vec[11] = '{0, 0, 32'h00, 1, 0, 4'hF, 32'h14,   32'h0,        1, 1,  0, 1, 1, 0, 0, 32'h0};
      vec[12] = '{0, 0, 32'h00, 1, 0, 4'hF, 32'h18,   32'h0,        1, 1,  0, 0, 0, 0, 0, 32'h0};
      vec[13] = '{0, 0, 32'h00, 1, 0, 4'hF, 32'h18,   32'h0,        1, 1,  0, 0, 0, 0, 0, 32'h0};
      vec[14] = '{0, 0, 32'h00, 1, 0, 4'hF, 32'h18,   32'h0,        1, 0,  0, 0, 0, 0, 1, 32'hA500_0004};
      vec[15] = '{0, 0, 32'h00, 1, 0, 4'hF, 32'h18,   32'h0,        1, 1,  0, 1, 1, 0, 0, 32'h0};
      vec[16] = '{0, 0, 32'h00, 0, 0, 4'hF, 32'h0,    32'h0,        1, 0,  0, 0, 0, 0, 1, 32'hA500_0005};
      vec[17] = '{0, 0, 32'h00, 0, 0, 4'hF, 32'h0,    32'h0,        1, 0,  0, 0, 0, 0, 1, 32'hA500_0006};
      vec[18] = '{0, 1, 32'h88, 0, 0, 4'hF, 32'h0,    32'h0,        0, 0,  0, 0, 1, 0, 0, 32'h0};
      vec[19] = '{0, 1, 32'h88, 0, 0, 4'hF, 32'h0,    32'h0,        1, 0,  1, 0, 1, 0, 0, 32'h0};
      vec[20] = '{0, 0, 32'h00, 0, 0, 4'hF, 32'h0,    32'h0,        1, 0,  0, 0, 0, 1, 0, 32'hA500_0022};

      rst_sys_i = 1'b1; instr_req_i = 1'b0; instr_addr_i = '0;
      data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'hF;
      data_addr_i = '0; data_wdata_i = '0; mem_gnt_i = 1'b1;
      mem_rvalid_i = 1'b0; mem_rdata_i = '0;
      @(posedge clk_sys_i);
      #1;

      for (int k = 0; k < 21; k++) begin
         rst_sys_i = vec[k].rst;  instr_req_i = vec[k].ir; instr_addr_i = vec[k].iaddr;
         data_req_i = vec[k].dr;  data_we_i = vec[k].we;   data_be_i = vec[k].be;
         data_addr_i = vec[k].daddr; data_wdata_i = vec[k].wdata;
         mem_gnt_i = vec[k].mg;   hold = vec[k].hold;
         tick();
         chk($sformatf("tbl%0d_instr_gnt", k),    cur_act.gi,    vec[k].gi);
         chk($sformatf("tbl%0d_data_gnt", k),     cur_act.gd,    vec[k].gd);
         chk($sformatf("tbl%0d_mem_req", k),      cur_act.mr,    vec[k].mr);
         chk($sformatf("tbl%0d_instr_rvalid", k), cur_act.rvi,   vec[k].rvi);
         chk($sformatf("tbl%0d_data_rvalid", k),  cur_act.rvd,   vec[k].rvd);
         chk($sformatf("tbl%0d_rdata", k),        cur_act.rdata, vec[k].rdata);
      end

      // Starvation: both hosts requesting continuously, fetch wins every
      // (MaxWait+1)th contended cycle.
      instr_req_i = 1'b1; instr_addr_i = 32'h90;
      data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h20;
      mem_gnt_i = 1'b1; hold = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk($sformatf("starve%0d_instr_gnt", k), cur_act.gi, (k == 5 || k == 10));
         chk($sformatf("starve%0d_data_gnt", k),  cur_act.gd, !(k == 5 || k == 10));
      end

      // Load outside the SRAM window
      instr_req_i = 1'b0;
      data_addr_i = 32'h2000_0000;
      tick();
      chk("range_mem_req",  cur_act.mr,    !RangeEn);
      chk("range_data_gnt", cur_act.gd,    1'b1);
      chk("range_mem_addr", cur_act.maddr, RangeEn ? 32'h0 : 32'h2000_0000);
      data_req_i = 1'b0;
      tick();
      chk("range_data_rvalid", cur_act.rvd,   1'b1);
      chk("range_err",         cur_act.err,   RangeEn);
      chk("range_rdata",       cur_act.rdata, RangeEn ? 32'h0 : 32'hA500_0000);

      // Randomized traffic; hosts keep req/addr stable until granted.
      for (int c = 0; c < 2000; c++) begin
         rst_sys_i = ($urandom_range(0, 99) == 0);
         instr_turn = !instr_req_i || cur_exp.gi;
         if (instr_turn) begin
            instr_req_i  = ($urandom_range(0, 1) == 1);
            instr_addr_i = rand_addr();
         end
         if (!data_req_i || cur_exp.gd) begin
            data_req_i   = ($urandom_range(0, 4) < 3);
            data_we_i    = $urandom_range(0, 1);
            data_be_i    = $urandom_range(0, 15);
            data_addr_i  = rand_addr();
            data_wdata_i = $urandom;
         end
         mem_gnt_i = ($urandom_range(0, 3) != 0);
         hold      = ($urandom_range(0, 3) == 0);
         tick();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-host arbiter for the shared single-port SoC SRAM. It muxes the core's instruction-fetch and load/store ports onto one memory port. Arbitration is data-priority with an anti-starvation override for fetch. In-order responses are routed back through a 2-entry owner FIFO. It sits between the core and the RAM wrapper inside the SoC top.

## Interface

- MemBase, 32'h0000_0000, byte base address of the SRAM window
- MemSize, 32'h0001_0000, SRAM window size in bytes (power of two)
- MaxWait, 4, consecutive cycles a pending fetch may lose before it gets priority (1..15)
- clk_sys_i  in  1  system clock
- rst_sys_i  in  1  reset, synchronous, active-high
- instr_req_i  in  1  fetch request
- instr_addr_i  in  32  fetch byte address
- instr_gnt_o  out  1  fetch request accepted this cycle
- instr_rvalid_o  out  1  fetch response valid
- data_req_i  in  1  load/store request
- data_we_i  in  1  1 = store
- data_be_i  in  4  store byte enables
- data_addr_i  in  32  load/store byte address
- data_wdata_i  in  32  store data
- data_gnt_o  out  1  load/store request accepted this cycle
- data_rvalid_o  out  1  load/store response valid
- rdata_o  out  32  response data, shared, qualified by the per-host rvalid
- err_o  out  1  response error, shared, qualified by the per-host rvalid
- mem_req_o  out  1  SRAM request
- mem_we_o  out  1  SRAM write enable
- mem_be_o  out  4  SRAM byte enables
- mem_addr_o  out  32  SRAM byte address
- mem_wdata_o  out  32  SRAM write data
- mem_gnt_i  in  1  SRAM accepted request
- mem_rvalid_i  in  1  SRAM response valid, in order
- mem_rdata_i  in  32  SRAM read data

## Operation

- State:
  - owner FIFO, 2 entries × {owner: 0 = instr, 1 = data; err}, with count_q in 0..2.
  - starve_q, $clog2(MaxWait+1) bits, saturating.
- Selection, each cycle:
  - Only data_req_i: data.
  - Only instr_req_i: instr.
  - Both: data, unless starve_q == MaxWait, in which case instr.
- Selected host's we/be/addr/wdata drive mem_*. Fetch drives mem_we_o = 0 and mem_be_o = 4'hF.
- Idle mem_* data fields are 0.
- mem_req_o = selected request && count_q < 2 && !rst_sys_i.
- Selected host's gnt_o = mem_req_o && mem_gnt_i. The unselected host's gnt_o is 0.
- On a grant, push {owner, err = 0}.
- starve_q:
  - +1 when instr_req_i && !instr_gnt_o.
  - Cleared on instr_gnt_o or !instr_req_i.
  - Saturates at MaxWait.
- Response for a head entry with err = 0:
  - On mem_rvalid_i, assert the owner's rvalid_o.
  - rdata_o = mem_rdata_i, err_o = 0, pop.
- mem_rvalid_i with an empty FIFO is ignored. rdata_o = 0 when no rvalid.
- Push and pop in the same cycle are allowed; count_q is unchanged.

## Timing

- Grant is combinational, same cycle as req && mem_gnt_i && not full.
- Response appears the cycle mem_rvalid_i arrives. Against the current 1-cycle SRAM, load-to-rvalid is 1 cycle.
- Back-to-back grants are sustained at 1 per cycle. The FIFO never fills with a 1-cycle SRAM.
- While rst_sys_i is high:
  - All outputs are 0.
  - count_q = 0 and starve_q = 0 at the next edge.
- Reset mid-operation drops outstanding entries. Stale mem_rvalid_i after reset is ignored.
- Hosts hold req/addr stable until gnt. The arbiter does not register host requests.

## Configuration

- SRAM_ARB_RANGE_CHECK_EN defined:
  - A request with addr outside [MemBase, MemBase+MemSize) is not forwarded; mem_req_o stays 0 for it.
  - That request is granted if count_q < 2, pushing {owner, err = 1}.
  - When an err entry reaches the head, the owner's rvalid_o = 1, err_o = 1 and rdata_o = 0 in that cycle, then pop, with no mem_rvalid_i needed.
  - Response order is preserved.
- SRAM_ARB_RANGE_CHECK_EN undefined: no range check; all requests are forwarded; err_o is always 0.

## Test plan

- Reset then idle: rst_sys_i = 1 for 3 cycles → all outputs 0. Release with no requests → mem_req_o = 0, count_q = 0.
- Fetch alone: instr_req_i at addr 0x80, SRAM returns 0x00000013 → instr_gnt_o same cycle; 1 cycle later instr_rvalid_o = 1, rdata_o = 0x13; data_rvalid_o stays 0.
- Store/fetch collision: data_req_i store 0x12345678, be = 4'hF, addr 0x1000, with instr_req_i every cycle → data granted first; mem_we_o = 1, mem_addr_o = 0x1000, mem_wdata_o = 0x12345678. A following load of 0x1000 returns 0x12345678 on data_rvalid_o.
- Starvation: data_req_i held for 10 cycles, instr_req_i held, MaxWait = 4 → instr_gnt_o asserts on the 5th contended cycle; starve_q clears; data is granted the next cycle.
- Full FIFO: mem_rvalid_i held low, 3 data requests → 2 grants, then data_gnt_o = 0 and mem_req_o = 0 until one mem_rvalid_i pulse frees a slot.
- Range error (macro defined): data load at 0x2000_0000 with MemSize = 0x1_0000 → mem_req_o = 0; data_gnt_o = 1; next cycle data_rvalid_o = 1, err_o = 1, rdata_o = 0. With the macro undefined, the same load is forwarded with mem_addr_o = 0x2000_0000 and err_o = 0.
